imem_loader: RTL and testbench

- Responder end of the instruction-memory bus. Answers fetch addresses from a word-addressed instruction array.
- Read is combinational: `data` is valid in the same cycle as `addr`, which is what the single-cycle fetch stage needs.
- Contains a boot-loader FSM that fills the array from a little-endian byte stream before the CPU runs.
- `loading` holds the core in reset/stall until the program is in place.

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory with a boot loader.
// The memory is filled from a little-endian byte stream while in LOAD and then read
// combinationally by the fetch stage while in RUN. The array contents are not reset.
// DEPTH_WORDS must be a power of two and at least 4.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] FILL_WORD   = 32'h00000013,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   addr,
    output logic [31:0]   data,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload_req,
    output logic          loading,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          err_overflow
);

    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH_WORDS);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e        state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    // Lanes 0..2 only; the lane-3 byte goes straight into the committed word.
    logic [23:0]   asm_q, asm_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic          load_done_q, load_done_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          mem_full;
    logic          mem_we;
    logic [31:0]   wdata;
    logic [AW-1:0] word_idx;
    logic          unused_addr_lsb;

    assign accept   = ld_valid && ld_ready;
    // A word is committed when lane 3 fills or when the last byte pads a partial word.
    assign commit   = accept && ((lane_q == 2'd3) || ld_last);
    assign mem_full = (word_count_q == FullCount);
    assign mem_we   = commit && !mem_full;
    // asm_q lanes at and above lane_q are always zero, so OR-ing yields zero padding.
    assign wdata    = {8'h00, asm_q} | ({24'h000000, ld_byte} << {lane_q, 3'b000});

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: if (accept && ld_last) state_d = StRun;
            StRun:  if (reload_req)        state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    // FSM outputs
    always_comb begin
        loading  = (state_q == StLoad);
        ld_ready = (state_q == StLoad);
    end

    // Datapath registers: lane counter, assembly word, counters and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q       <= 2'd0;
            asm_q        <= 24'h000000;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
            err_q        <= err_d;
        end
    end

    // Datapath next-state: byte assembly, commit counting, overflow, reload clearing
    always_comb begin
        lane_d       = lane_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        err_d        = err_q;
        if (state_q == StLoad) begin
            if (accept) begin
                if (commit) begin
                    lane_d = 2'd0;
                    asm_d  = 24'h000000;
                    if (mem_full) begin
                        err_d = 1'b1;
                    end else begin
                        word_count_d = word_count_q + 1'b1;
                    end
                end else begin
                    lane_d = lane_q + 2'd1;
                    asm_d  = asm_q | ({16'h0000, ld_byte} << {lane_q, 3'b000});
                end
                if (ld_last) begin
                    load_done_d = 1'b1;
                end
            end
        end else if (reload_req) begin
            lane_d       = 2'd0;
            asm_d        = 24'h000000;
            word_count_d = '0;
            load_done_d  = 1'b0;
            err_d        = 1'b0;
        end
    end

    // Memory write port; deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_count_q[AW-1:0]] <= wdata;
        end
    end

    assign word_idx        = addr[AW+1:2];
    assign unused_addr_lsb = ^addr[1:0];

    // Combinational fetch read; NOP while loading or for addresses beyond the array
    always_comb begin
        data = FILL_WORD;
        if (!loading && (addr[31:AW+2] == '0)) begin
            data = mem[word_idx];
        end
    end

    assign word_count   = word_count_q;
    assign load_done    = load_done_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 256-word instance for the main flows and a
// 4-word instance for overflow. Expected reads are queued and compared on drain.
module tb_imem_loader;

    localparam logic [31:0] Nop = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] addr, data;
    logic        ld_valid, ld_last, ld_ready, reload_req, loading, load_done, err_overflow;
    logic [7:0]  ld_byte;
    logic [8:0]  word_count;

    logic [31:0] addr4, data4;
    logic        ld_valid4, ld_last4, ld_ready4, reload_req4, loading4, load_done4, err4;
    logic [7:0]  ld_byte4;
    logic [2:0]  word_count4;

    typedef struct {
        bit          sel;
        string       tag;
        logic [31:0] a;
        logic [31:0] e;
    } rd_t;

    rd_t sb[$];
    int  n_checks = 0;
    int  n_fail = 0;

    logic [7:0] basic [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    imem_loader #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset), .addr(addr), .data(data),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
        .reload_req(reload_req), .loading(loading), .load_done(load_done),
        .word_count(word_count), .err_overflow(err_overflow)
    );

    imem_loader #(.DEPTH_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr4), .data(data4),
        .ld_valid(ld_valid4), .ld_byte(ld_byte4), .ld_last(ld_last4), .ld_ready(ld_ready4),
        .reload_req(reload_req4), .loading(loading4), .load_done(load_done4),
        .word_count(word_count4), .err_overflow(err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] b, input bit l);
        @(negedge clk);
        ld_valid = v;
        ld_byte  = b;
        ld_last  = l;
    endtask

    task automatic drive4(input bit v, input logic [7:0] b, input bit l);
        @(negedge clk);
        ld_valid4 = v;
        ld_byte4  = b;
        ld_last4  = l;
    endtask

    task automatic reload();
        @(negedge clk);
        reload_req = 1'b1;
        @(negedge clk);
        reload_req = 1'b0;
    endtask

    task automatic push_read(input bit sel, input string tag, input logic [31:0] a,
                             input logic [31:0] e);
        rd_t r;
        r.sel = sel;
        r.tag = tag;
        r.a   = a;
        r.e   = e;
        sb.push_back(r);
    endtask

    task automatic drain_reads();
        while (sb.size() > 0) begin
            rd_t r;
            r = sb.pop_front();
            @(negedge clk);
            if (r.sel) addr4 = r.a;
            else       addr  = r.a;
            #1;
            chk(r.tag, r.sel ? data4 : data, r.e);
        end
    endtask

    initial begin
        int k;
        int cyc;
        logic [31:0] w;

        addr = '0; ld_valid = 0; ld_byte = '0; ld_last = 0; reload_req = 0;
        addr4 = '0; ld_valid4 = 0; ld_byte4 = '0; ld_last4 = 0; reload_req4 = 0;

        // Reset state
        #12;
        chk("rst_loading", 32'(loading), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        chk("rst_data_fill", data, Nop);
        @(negedge clk);
        reset = 1'b0;

        // Overflow on the 4-word instance: 20 bytes, last on the 20th
        for (int i = 0; i < 20; i++) begin
            drive4(1'b1, 8'(i), i == 19);
            if (i == 16) begin
                chk("ovf_full_count", 32'(word_count4), 32'd4);
                chk("ovf_not_yet", 32'(err4), 32'd0);
            end
        end
        drive4(1'b0, 8'h00, 1'b0);
        chk("ovf_err", 32'(err4), 32'd1);
        chk("ovf_count_sat", 32'(word_count4), 32'd4);
        chk("ovf_run", 32'(loading4), 32'd0);
        chk("ovf_done", 32'(load_done4), 32'd1);
        for (int j = 0; j < 4; j++) begin
            w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            push_read(1'b1, $sformatf("ovf_mem%0d", j), 32'(4*j), w);
        end
        push_read(1'b1, "ovf_oor", 32'h10, Nop);
        drain_reads();

        // Basic load
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, basic[i], i == 7);
            if (i == 5) begin
                addr = 32'h0;
                #1;
                chk("basic_fill_loading", data, Nop);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("basic_count", 32'(word_count), 32'd2);
        chk("basic_done", 32'(load_done), 32'd1);
        chk("basic_loading", 32'(loading), 32'd0);
        chk("basic_ready", 32'(ld_ready), 32'd0);
        chk("basic_err", 32'(err_overflow), 32'd0);
        push_read(1'b0, "basic_mem0", 32'h0, 32'h00000013);
        push_read(1'b0, "basic_mem1", 32'h4, 32'h00100093);
        push_read(1'b0, "basic_mem1_unaligned", 32'h6, 32'h00100093);
        drain_reads();

        // Reload with a byte offered in the same cycle: that byte must be dropped
        @(negedge clk);
        reload_req = 1'b1;
        ld_valid   = 1'b1;
        ld_byte    = 8'hAA;
        @(negedge clk);
        reload_req = 1'b0;
        ld_valid   = 1'b0;
        chk("reload_loading", 32'(loading), 32'd1);
        chk("reload_count", 32'(word_count), 32'd0);
        chk("reload_done_clr", 32'(load_done), 32'd0);

        // Partial final word
        drive(1'b1, 8'h13, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'hB7, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        chk("partial_count", 32'(word_count), 32'd2);
        chk("partial_done", 32'(load_done), 32'd1);
        push_read(1'b0, "partial_mem0", 32'h0, 32'h00000013);
        push_read(1'b0, "partial_mem1", 32'h4, 32'h000000B7);
        drain_reads();

        // Backpressure: valid on every third cycle, with a stray ld_last while invalid
        reload();
        k = 0;
        cyc = 0;
        while (k < 8) begin
            if (cyc % 3 == 0) begin
                drive(1'b1, basic[k], k == 7);
                k++;
            end else begin
                drive(1'b0, 8'hFF, 1'b1);
                addr = $urandom & 32'h0000_03FC;
                #1;
                chk("bp_fill_loading", data, Nop);
            end
            cyc++;
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("bp_count", 32'(word_count), 32'd2);
        push_read(1'b0, "bp_mem0", 32'h0, 32'h00000013);
        push_read(1'b0, "bp_mem1", 32'h4, 32'h00100093);
        drain_reads();

        // Reload and load a single word
        reload();
        drive(1'b1, 8'h93, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b1, 8'h50, 1'b0);
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        chk("rl_count", 32'(word_count), 32'd1);
        chk("rl_done", 32'(load_done), 32'd1);
        push_read(1'b0, "rl_mem0", 32'h0, 32'h00500293);
        push_read(1'b0, "rl_mem1_kept", 32'h4, 32'h00100093);
        push_read(1'b0, "rl_oor_1000", 32'h1000, Nop);
        push_read(1'b0, "rl_oor_high", 32'h8000_0000, Nop);
        drain_reads();

        // Reset mid-load after 6 bytes
        reload();
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h66, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_loading", 32'(loading), 32'd1);
        chk("mid_rst_count", 32'(word_count), 32'd0);
        chk("mid_rst_done", 32'(load_done), 32'd0);
        chk("mid_rst_mem0", dut.mem[0], 32'h44332211);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'h77, 1'b0);
        drive(1'b1, 8'h88, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        chk("post_rst_count", 32'(word_count), 32'd1);
        push_read(1'b0, "post_rst_mem0", 32'h0, 32'h00008877);
        drain_reads();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
